maze_loader: RTL and testbench

//  Upstream fill stage for the rat-in-maze solver. Accepts the maze one row at a time over a

---
 rtl/maze_loader.sv | 144 ++++++++++++++
 tb/tb_maze_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_loader.sv
// Fill stage for the rat-in-maze solver: row handshake in, one cell write per cycle out.
// Validates that entry and exit are open before starting the solver.
module maze_loader #(
   parameter int ROW_W = 4,
   parameter int COL_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load_req,
   input  logic [2**COL_W-1:0]    row_data,
   input  logic                   row_valid,
   output logic                   row_ready,
   output logic [ROW_W+COL_W-1:0] mem_loc,
   output logic                   mem_din,
   output logic                   mem_wr,
   output logic                   busy,
   output logic                   start,
   output logic                   err
);

   localparam int COLS = 2**COL_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_ROW,
      S_WRITE,
      S_CHECK,
      S_START,
      S_FAIL
   } state_e;

   state_e                   state_q, state_d;
   logic [ROW_W-1:0]         row_q, row_d;
   logic [COL_W-1:0]         col_q, col_d;
   logic [COLS-1:0]          shift_q, shift_d;
   logic                     entry_q, entry_d;
   logic                     exit_q, exit_d;
   logic                     err_q, err_d;
   logic [ROW_W+COL_W-1:0]   loc_q, loc_d;
   logic                     din_q, din_d;

   logic last_col;
   logic last_row;
   logic first_cell;

   assign last_col   = &col_q;
   assign last_row   = &row_q;
   assign first_cell = (row_q == '0) && (col_q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         shift_q <= '0;
         entry_q <= 1'b0;
         exit_q  <= 1'b0;
         err_q   <= 1'b0;
         loc_q   <= '0;
         din_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         shift_q <= shift_d;
         entry_q <= entry_d;
         exit_q  <= exit_d;
         err_q   <= err_d;
         loc_q   <= loc_d;
         din_q   <= din_d;
      end
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      shift_d = shift_q;
      entry_d = entry_q;
      exit_d  = exit_q;
      err_d   = err_q;
      loc_d   = loc_q;
      din_d   = din_q;

      unique case (state_q)
         S_IDLE: begin
            if (load_req) begin
               state_d = S_WAIT_ROW;
               row_d   = '0;
               col_d   = '0;
               err_d   = 1'b0;
               entry_d = 1'b0;
               exit_d  = 1'b0;
            end
         end
         S_WAIT_ROW: begin
            if (row_valid) begin
               shift_d = row_data;
               col_d   = '0;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            // LSB of the shift register is always the cell at col_q
            shift_d = shift_q >> 1;
            col_d   = col_q + COL_W'(1);
            loc_d   = {row_q, col_q};
            din_d   = shift_q[0];
            if (first_cell)
               entry_d = shift_q[0];
            if (last_row && last_col)
               exit_d = shift_q[0];
            if (last_col) begin
               if (last_row) begin
                  state_d = S_CHECK;
               end else begin
                  row_d   = row_q + ROW_W'(1);
                  state_d = S_WAIT_ROW;
               end
            end
         end
         S_CHECK: begin
            if (entry_q || exit_q) begin
               err_d   = 1'b1;
               state_d = S_FAIL;
            end else begin
               state_d = S_START;
            end
         end
         S_START: state_d = S_IDLE;
         S_FAIL:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign mem_wr    = (state_q == S_WRITE);
   assign mem_loc   = mem_wr ? {row_q, col_q} : loc_q;
   assign mem_din   = mem_wr ? shift_q[0] : din_q;
   assign row_ready = (state_q == S_WAIT_ROW);
   assign busy      = (state_q != S_IDLE);
   assign start     = (state_q == S_START);
   assign err       = err_q;

endmodule

// File: tb/tb_maze_loader.sv
// Scoreboard bench for maze_loader: random mazes, expected writes and outcome
// come from a cell-array model; a negedge monitor pops and compares.
module tb_maze_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_req;
   logic [15:0] row_data;
   logic        row_valid;
   logic        row_ready;
   logic [7:0]  mem_loc;
   logic        mem_din;
   logic        mem_wr;
   logic        busy;
   logic        start;
   logic        err;

   always #5 clk = ~clk;

   maze_loader dut (
      .clk       (clk),
      .rst       (rst),
      .load_req  (load_req),
      .row_data  (row_data),
      .row_valid (row_valid),
      .row_ready (row_ready),
      .mem_loc   (mem_loc),
      .mem_din   (mem_din),
      .mem_wr    (mem_wr),
      .busy      (busy),
      .start     (start),
      .err       (err)
   );

   int tests = 0;
   int fails = 0;

   logic [8:0]  exp_wr[$];
   bit          exp_term[$];
   logic [15:0] maze[16];

   int cyc = 0;
   int t_ready = 0;
   int t_start = 0;
   bit rdy_seen = 1'b0;
   bit prev_start = 1'b0;
   bit prev_err = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (row_ready && !rdy_seen) begin
            rdy_seen = 1'b1;
            t_ready  = cyc;
         end
         if (mem_wr) begin
            if (exp_wr.size() == 0)
               chk("write_extra", {mem_loc, mem_din}, 512);
            else
               chk("write_loc_din", {mem_loc, mem_din}, exp_wr.pop_front());
         end
         if (start) begin
            t_start = cyc;
            if (exp_term.size() == 0)
               chk("start_unexpected", start, 0);
            else
               chk("outcome_start", 1, exp_term.pop_front());
            chk("err_at_start", err, 0);
         end
         if (err && !prev_err) begin
            if (exp_term.size() == 0)
               chk("err_unexpected", err, 0);
            else
               chk("outcome_err", 0, exp_term.pop_front());
         end
         if (prev_start) begin
            chk("start_one_cycle", start, 0);
            chk("idle_after_start", busy, 0);
         end
      end
      prev_start = start && !rst;
      prev_err   = err;
   end

   task automatic wait_ready(output bit ok);
      int n = 0;
      ok = 1'b1;
      forever begin
         @(negedge clk);
         if (row_ready) break;
         n++;
         if (n > 100) begin
            chk("row_ready_timeout", row_ready, 1);
            ok = 1'b0;
            break;
         end
      end
   endtask

   task automatic do_load(input int gap_row, input int gap_len,
                          input int req_row, input int abort_row,
                          input bit chk_time);
      bit ok;
      int n;
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++)
            exp_wr.push_back({4'(r), 4'(c), maze[r][c]});
      exp_term.push_back(!(maze[0][0] || maze[15][15]));
      rdy_seen = 1'b0;
      load_req = 1'b1;
      @(posedge clk); #1;
      load_req = 1'b0;
      chk("err_cleared_on_load", err, 0);
      chk("busy_after_req", busy, 1);
      for (int r = 0; r < 16; r++) begin
         if (r == gap_row) begin
            row_valid = 1'b0;
            wait_ready(ok);
            if (!ok) begin
               exp_wr.delete(); exp_term.delete();
               return;
            end
            repeat (gap_len) begin
               @(posedge clk); #1;
               chk("gap_ready_high", row_ready, 1);
               chk("gap_no_write", mem_wr, 0);
            end
         end
         row_data  = maze[r];
         row_valid = 1'b1;
         wait_ready(ok);
         if (!ok) begin
            row_valid = 1'b0;
            exp_wr.delete(); exp_term.delete();
            return;
         end
         @(posedge clk); #1;
         if (r == abort_row) begin
            repeat (5) @(posedge clk);
            #1;
            chk("abort_at_col5", mem_loc, {4'(r), 4'd5});
            rst = 1'b1;
            row_valid = 1'b0;
            @(posedge clk); #1;
            chk("abort_wr", mem_wr, 0);
            chk("abort_busy", busy, 0);
            chk("abort_ready", row_ready, 0);
            chk("abort_start", start, 0);
            chk("abort_loc", mem_loc, 0);
            rst = 1'b0;
            exp_wr.delete();
            exp_term.delete();
            return;
         end
         if (r == req_row) begin
            repeat (3) @(posedge clk);
            #1;
            load_req = 1'b1;
            @(posedge clk); #1;
            load_req = 1'b0;
         end
      end
      row_valid = 1'b0;
      n = 0;
      while (exp_term.size() != 0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("outcome_seen", exp_term.size(), 0);
      chk("writes_drained", exp_wr.size(), 0);
      chk("idle_after_load", busy, 0);
      if (chk_time)
         chk("start_latency", t_start - t_ready, 17 * 16 + 1);
   endtask

   task automatic rand_maze(input int walls);
      for (int r = 0; r < 16; r++)
         maze[r] = 16'($urandom & $urandom);
      maze[0][0]   = (walls == 0) || (walls == 2);
      maze[15][15] = (walls == 1) || (walls == 2);
   endtask

   initial begin
      rst       = 1'b1;
      load_req  = 1'b0;
      row_data  = '0;
      row_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", row_ready, 0);
      chk("rst_loc", mem_loc, 0);
      chk("rst_din", mem_din, 0);
      chk("rst_wr", mem_wr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_start", start, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // all-open maze with latency check
      for (int r = 0; r < 16; r++) maze[r] = 16'h0000;
      do_load(-1, 0, -1, -1, 1'b1);

      // stalled row 3 with walls at both ends
      maze[3] = 16'h8001;
      do_load(3, 5, -1, -1, 1'b0);

      // entry wall, sticky err
      for (int r = 0; r < 16; r++) maze[r] = 16'h0000;
      maze[0] = 16'h0001;
      do_load(-1, 0, -1, -1, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      chk("err_sticky", err, 1);
      chk("err_no_start", start, 0);

      // exit wall, then both walls
      maze[0]  = 16'h0000;
      maze[15] = 16'h8000;
      do_load(-1, 0, -1, -1, 1'b0);
      maze[0] = 16'h0001;
      do_load(-1, 0, -1, -1, 1'b0);

      // reset mid-write of row 7, then fresh load
      rand_maze(3);
      do_load(-1, 0, -1, 7, 1'b0);
      rand_maze(3);
      do_load(-1, 0, -1, -1, 1'b0);

      // load_req during row 2 writes must not disturb timing
      for (int r = 0; r < 16; r++) maze[r] = 16'h0000;
      do_load(-1, 0, 2, -1, 1'b1);

      for (int k = 0; k < 6; k++) begin
         rand_maze(int'($urandom_range(0, 5)));
         do_load(int'($urandom_range(0, 20)), int'($urandom_range(1, 6)),
                 -1, -1, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
